// File: rtl/gcd_rr_scheduler_if.sv
// Request/response channel bundle between the GCD clients and the round-robin scheduler.
// The master modport is the client side. The slave modport is the scheduler side.
interface gcd_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end for one shared iterative GCD engine.
// Clients are accepted one at a time. Jobs with a zero operand are answered locally.
// Every other job is started on the engine and guarded by a watchdog.
// The result goes back on one tagged response channel.
module gcd_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 600,
  parameter int IDW     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_rr_scheduler_if.slave bus,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             busy
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;
  logic             eng_start_q;
  logic             rsp_valid_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic [WIDTH-1:0]   a_in, b_in;
  logic [IDW-1:0]     ptr_d;
  int                 idx;

  // Pick the first valid requester, scanning up from the pointer with wrap. Only in IDLE.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

  // Reset forces the ready lines low at once. The grant term alone would still show the IDLE grant.
  assign bus.req_ready = gnt & {NUM_REQ{rst_n}};

  assign a_in  = bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign b_in  = bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign ptr_d = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + IDW'(1);

  // Scheduler FSM. It also registers the engine and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_any && rst_n) begin
            id_q <= gnt_id;
            a_q  <= a_in;
            b_q  <= b_in;
            if (a_in == '0 || b_in == '0) begin
              // gcd(x,0)=x and gcd(0,0)=0. No engine trip is needed.
              res_q       <= a_in | b_in;
              err_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // eng_done seen in this cycle is stale, so it is ignored.
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (eng_done) begin
            res_q       <= eng_result;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT-1)) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_start      = eng_start_q;
  assign eng_a          = a_q;
  assign eng_b          = b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_err    = err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed and random bench for gcd_rr_scheduler. It uses a behavioural GCD engine,
// a response scoreboard and a round-robin ready model.
module tb_gcd_rr_scheduler;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 600;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a, req_b;
  logic            rsp_ready;
  logic            eng_start, eng_done, busy;
  logic [W-1:0]    eng_a, eng_b, eng_result;

  gcd_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(W), .IDW(2)) bus ();
  assign bus.req_valid = req_valid;
  assign bus.req_a     = req_a;
  assign bus.req_b     = req_b;
  assign bus.rsp_ready = rsp_ready;

  gcd_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, start_cyc = 0, rsp_cyc = 0, n_start = 0;
  int lat = 2;
  logic stuck = 1'b0, rnd_rdy = 1'b0, m_busy = 1'b0, prev_rv = 1'b0;
  logic [1:0] m_ptr = '0;
  logic [NR-1:0] pend_clr = '0;
  exp_t sb[$];
  int   acc_ids[$];

  function automatic logic [7:0] f_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Behavioural engine: answers after lat+1 WAIT cycles, or never when stuck.
  logic       e_busy;
  logic [7:0] e_res;
  int         e_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_busy <= 1'b0; e_cnt <= 0; e_res <= '0; eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        e_busy <= 1'b1; e_cnt <= lat; e_res <= f_gcd(eng_a, eng_b);
      end else if (e_busy && !stuck) begin
        if (e_cnt == 0) begin eng_done <= 1'b1; e_busy <= 1'b0; end
        else e_cnt <= e_cnt - 1;
      end
    end
  end
  assign eng_result = eng_done ? e_res : 8'hA5;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks ready against the round-robin model, pushes expected results on accept,
  // and pops and compares them on response handshake.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] acc;
    int id, ix;
    exp_t e;
    if (!rst_n) begin
      sb.delete(); m_busy = 1'b0; m_ptr = '0; prev_rv = 1'b0;
    end else begin
      exp_rdy = '0;
      if (!m_busy) begin
        for (int k = 0; k < NR; k++) begin
          ix = (int'(m_ptr) + k) % NR;
          if (exp_rdy == '0 && req_valid[ix]) exp_rdy[ix] = 1'b1;
        end
      end
      check("req_ready", bus.req_ready, exp_rdy);
      if (eng_start) begin n_start++; start_cyc = cyc; end
      if (bus.rsp_valid && !prev_rv) rsp_cyc = cyc;
      prev_rv = bus.rsp_valid;
      acc = req_valid & bus.req_ready;
      if (acc != '0) begin
        id = 0;
        for (int k = NR-1; k >= 0; k--) if (acc[k]) id = k;
        e.id = 2'(id);
        if (stuck && req_a[id*W +: W] != 0 && req_b[id*W +: W] != 0) begin
          e.res = '0; e.err = 1'b1;
        end else begin
          e.res = f_gcd(req_a[id*W +: W], req_b[id*W +: W]); e.err = 1'b0;
        end
        sb.push_back(e);
        acc_ids.push_back(id);
        acc_cyc = cyc;
        m_busy = 1'b1;
        pend_clr = pend_clr | acc;
      end
      if (bus.rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_spurious", bus.rsp_valid, 0);
        else begin
          e = sb.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_result", bus.rsp_result, e.res);
          check("rsp_err", bus.rsp_err, e.err);
          m_ptr = e.id + 2'd1;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  // Hold each request until it is accepted, then drop it.
  task automatic drain(input int budget);
    int n = 0;
    while (req_valid != 0 && n < budget) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~pend_clr;
      pend_clr = '0;
      if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (req_valid != 0) begin timeout_fail("drain_timeout"); req_valid = '0; end
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      @(posedge clk); #1;
      if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (m_busy) timeout_fail("quiet_timeout");
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, {bus.rsp_id, bus.rsp_result, bus.rsp_err}, 0);
    check({tag, "_eng"}, {eng_start, eng_a, eng_b}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int s0, n, jobs;
    logic [NR-1:0] mask;
    rst_n = 1'b0; rsp_ready = 1'b1;
    // Test 2 stimulus is held from reset: pairs (12,8) (9,6) (100,75) (7,5).
    req_a = {8'd7, 8'd100, 8'd9, 8'd12};
    req_b = {8'd5, 8'd75, 8'd6, 8'd8};
    req_valid = 4'hF;
    #3;
    reset_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 2: all four valid, so the accept order is 0,1,2,3. Then only 0 and 2 are valid.
    drain(200); wait_quiet(200);
    check("ord4_n", acc_ids.size(), 4);
    for (int k = 0; k < 4; k++) if (k < acc_ids.size()) check("ord4", acc_ids[k], k);
    acc_ids.delete();
    drive(0, 8'd30, 8'd45); drive(2, 8'd17, 8'd0);
    drain(200); wait_quiet(200);
    check("ord2_n", acc_ids.size(), 2);
    if (acc_ids.size() == 2) begin check("ord2_a", acc_ids[0], 0); check("ord2_b", acc_ids[1], 2); end

    // Test 1: one engine job from requester 0, gcd(48,18)=6.
    s0 = n_start;
    drive(0, 8'd48, 8'd18); drain(100); wait_quiet(200);
    check("t1_starts", n_start - s0, 1);
    check("t1_start_lat", start_cyc - acc_cyc, 1);

    // Test 3: zero-operand bypass. There is no engine start and the response comes at T+1.
    s0 = n_start;
    drive(1, 8'd0, 8'd35); drain(100); wait_quiet(100);
    check("t3_starts", n_start - s0, 0);
    check("t3_rsp_lat", rsp_cyc - acc_cyc, 1);
    drive(1, 8'd0, 8'd0); drain(100); wait_quiet(100);
    check("t3_zz_starts", n_start - s0, 0);

    // Test 4: the engine never finishes, so the watchdog answers after TIMEOUT WAIT cycles.
    stuck = 1'b1;
    drive(3, 8'd10, 8'd4); drain(100); wait_quiet(TO + 100);
    check("t4_timeout_lat", rsp_cyc - start_cyc, TO + 1);
    stuck = 1'b0;
    drive(3, 8'd21, 8'd14); drain(100); wait_quiet(200);

    // Test 5: response back-pressure. req0 waits while the req2 response is held.
    rsp_ready = 1'b0;
    drive(2, 8'd36, 8'd24); drain(100);
    drive(0, 8'd5, 8'd10);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 200);
    if (!bus.rsp_valid) timeout_fail("t5_rsp_wait");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t5_rsp_valid", bus.rsp_valid, 1);
      check("t5_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_err}, {2'd2, 8'd12, 1'b0});
      check("t5_ready", bus.req_ready, 0);
      check("t5_busy", busy, 1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain(100); wait_quiet(200);

    // Test 6: reset in the middle of WAIT. The pointer was 1 before this job.
    lat = 100;
    s0 = n_start;
    drive(1, 8'd255, 8'd1); drain(100);
    n = 0;
    while (n_start == s0 && n < 50) begin @(posedge clk); #1; n++; end
    if (n_start == s0) timeout_fail("t6_start_wait");
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_outputs_zero("t6_async");
    @(posedge clk); #1 rst_n = 1'b1;
    lat = 2;
    for (int k = 0; k < 10; k++) begin @(negedge clk); check("t6_no_rsp", bus.rsp_valid, 0); end
    acc_ids.delete();
    @(posedge clk); #1;
    drive(1, 8'd9, 8'd3); drive(0, 8'd8, 8'd4);
    drain(200); wait_quiet(200);
    check("t6_ord_n", acc_ids.size(), 2);
    if (acc_ids.size() == 2) begin check("t6_ord_a", acc_ids[0], 0); check("t6_ord_b", acc_ids[1], 1); end

    // Random phase: 1000 pairs across random requester sets, with random back-pressure.
    rnd_rdy = 1'b1;
    jobs = 0;
    while (jobs < 1000) begin
      mask = 4'($urandom_range(1, 15));
      lat = $urandom_range(0, 5);
      for (int i = 0; i < NR; i++)
        if (mask[i] && jobs < 1000) begin
          drive(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          jobs++;
        end
      drain(2000);
    end
    rnd_rdy = 1'b0; rsp_ready = 1'b1;
    wait_quiet(500);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
